// File: rtl/batalha_pkg.sv
// Shared constants and state encoding for the battleship shot responder.
package batalha_pkg;

    localparam int GRID_BITS   = 3;
    localparam int ADDR_BITS   = 2 * GRID_BITS;
    localparam int TOTAL_CELLS = 12;
    localparam int CNT_BITS    = 4;

    localparam logic P1 = 1'b0;
    localparam logic P2 = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LER  = 2'd1;
    localparam logic [1:0] ST_AVAL = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LER  = ST_LER,
        AVAL = ST_AVAL,
        RESP = ST_RESP
    } estado_t;

endpackage

// File: rtl/respondedor_tiro_if.sv
// Shot request/response plus board-memory read port between game FSM and responder.
interface respondedor_tiro_if #(
    parameter int GRID_BITS = batalha_pkg::GRID_BITS
);
    logic                   clear;
    logic                   valida;
    logic [GRID_BITS-1:0]   coord_x;
    logic [GRID_BITS-1:0]   coord_y;
    logic                   jogador;
    logic                   rd_en;
    logic                   rd_jogador;
    logic [2*GRID_BITS-1:0] rd_addr;
    logic                   rd_data;
    logic                   ocupado;
    logic                   pronto;
    logic                   acertou_tiro;
    logic                   repetido;
    logic                   fim_jogo;
    logic                   vencedor;

    modport master (
        output clear, valida, coord_x, coord_y, jogador, rd_data,
        input  rd_en, rd_jogador, rd_addr, ocupado, pronto,
               acertou_tiro, repetido, fim_jogo, vencedor
    );

    modport slave (
        input  clear, valida, coord_x, coord_y, jogador, rd_data,
        output rd_en, rd_jogador, rd_addr, ocupado, pronto,
               acertou_tiro, repetido, fim_jogo, vencedor
    );
endinterface

// File: rtl/mapa_tiros.sv
// Record of cells already shot on one player's board: sync set/clear, comb lookup.
module mapa_tiros #(
    parameter int ADDR_BITS = batalha_pkg::ADDR_BITS
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 set_en,
    input  logic [ADDR_BITS-1:0] addr,
    output logic                 tiro_feito
);

    logic [2**ADDR_BITS-1:0] mapa;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mapa <= '0;
        end else if (clear) begin
            mapa <= '0;
        end else if (set_en) begin
            mapa[addr] <= 1'b1;
        end
    end

    assign tiro_feito = mapa[addr];

endmodule

// File: rtl/respondedor_tiro.sv
// Shot responder: reads the target board, flags hit/repeat, counts hits, declares winner.
// state | meaning
// IDLE  | waiting for a shot request
// LER   | board read issued for the latched cell
// AVAL  | board data valid; results, map and counters updated
// RESP  | one-cycle pronto strobe
module respondedor_tiro
    import batalha_pkg::*;
#(
    parameter int GRID_BITS   = batalha_pkg::GRID_BITS,
    parameter int TOTAL_CELLS = batalha_pkg::TOTAL_CELLS,
    parameter int CNT_BITS    = batalha_pkg::CNT_BITS
) (
    input  logic               clk,
    input  logic               reset,
    respondedor_tiro_if.slave  tiro
);

    localparam int ADDR_W = 2 * GRID_BITS;
    localparam logic [CNT_BITS-1:0] TOTAL = CNT_BITS'(TOTAL_CELLS);

    estado_t             estado;
    logic [ADDR_W-1:0]   addr;
    logic                jog;
    logic                alvo;
    logic                rd_en_q;
    logic                ocupado_q;
    logic                pronto_q;
    logic                acertou_q;
    logic                repetido_q;
    logic                fim_q;
    logic                vencedor_q;
    logic [CNT_BITS-1:0] hits_p1;
    logic [CNT_BITS-1:0] hits_p2;
    logic [CNT_BITS-1:0] hit_sel;
    logic [CNT_BITS-1:0] hit_next;
    logic                rep_p1;
    logic                rep_p2;
    logic                rep;
    logic                marca;

    // alvo is the registered ~jogador, so it doubles as the target-board select
    assign rep      = (alvo == P2) ? rep_p2 : rep_p1;
    assign marca    = (estado == AVAL) && !tiro.clear && !rep;
    assign hit_sel  = (jog == P2) ? hits_p2 : hits_p1;
    assign hit_next = hit_sel + CNT_BITS'(1);

    mapa_tiros #(.ADDR_BITS(ADDR_W)) u_mapa_p1 (
        .clk        (clk),
        .reset      (reset),
        .clear      (tiro.clear),
        .set_en     (marca && (alvo == P1)),
        .addr       (addr),
        .tiro_feito (rep_p1)
    );

    mapa_tiros #(.ADDR_BITS(ADDR_W)) u_mapa_p2 (
        .clk        (clk),
        .reset      (reset),
        .clear      (tiro.clear),
        .set_en     (marca && (alvo == P2)),
        .addr       (addr),
        .tiro_feito (rep_p2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado     <= IDLE;
            addr       <= '0;
            jog        <= P1;
            alvo       <= 1'b0;
            rd_en_q    <= 1'b0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
            acertou_q  <= 1'b0;
            repetido_q <= 1'b0;
            fim_q      <= 1'b0;
            vencedor_q <= 1'b0;
            hits_p1    <= '0;
            hits_p2    <= '0;
        end else if (tiro.clear) begin
            estado     <= IDLE;
            rd_en_q    <= 1'b0;
            ocupado_q  <= 1'b0;
            pronto_q   <= 1'b0;
            fim_q      <= 1'b0;
            vencedor_q <= 1'b0;
            hits_p1    <= '0;
            hits_p2    <= '0;
        end else begin
            case (estado)
                IDLE: begin
                    if (tiro.valida && !fim_q) begin
                        addr      <= {tiro.coord_y, tiro.coord_x};
                        jog       <= tiro.jogador;
                        alvo      <= ~tiro.jogador;
                        rd_en_q   <= 1'b1;
                        ocupado_q <= 1'b1;
                        estado    <= LER;
                    end
                end
                LER: begin
                    rd_en_q <= 1'b0;
                    estado  <= AVAL;
                end
                AVAL: begin
                    if (rep) begin
                        repetido_q <= 1'b1;
                        acertou_q  <= 1'b0;
                    end else begin
                        repetido_q <= 1'b0;
                        acertou_q  <= tiro.rd_data;
                        if (tiro.rd_data && (hit_sel < TOTAL)) begin
                            if (jog == P2) hits_p2 <= hit_next;
                            else           hits_p1 <= hit_next;
                            if (hit_next == TOTAL) begin
                                fim_q      <= 1'b1;
                                vencedor_q <= jog;
                            end
                        end
                    end
                    pronto_q <= 1'b1;
                    estado   <= RESP;
                end
                RESP: begin
                    pronto_q  <= 1'b0;
                    ocupado_q <= 1'b0;
                    estado    <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end

    assign tiro.rd_en        = rd_en_q;
    assign tiro.rd_jogador   = alvo;
    assign tiro.rd_addr      = addr;
    assign tiro.ocupado      = ocupado_q;
    assign tiro.pronto       = pronto_q;
    assign tiro.acertou_tiro = acertou_q;
    assign tiro.repetido     = repetido_q;
    assign tiro.fim_jogo     = fim_q;
    assign tiro.vencedor     = vencedor_q;

endmodule

// File: tb/tb_respondedor_tiro.sv
// Bench for respondedor_tiro: board memory model, response scoreboard, vector table.
module tb_respondedor_tiro;

    typedef struct packed {
        logic hit;
        logic rep;
        logic fim;
        logic venc;
    } resp_t;

    typedef struct {
        logic [2:0] x;
        logic [2:0] y;
        logic       j;
        resp_t      exp;
    } vec_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    respondedor_tiro_if ifc ();

    respondedor_tiro dut (
        .clk   (clk),
        .reset (rst),
        .tiro  (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // board[p][cell] = 1 means a ship of player p sits on that cell
    logic board [2][64];

    always @(posedge clk) begin
        if (ifc.rd_en) ifc.rd_data <= board[ifc.rd_jogador][ifc.rd_addr];
    end

    int    cyc = 0;
    int    pronto_count = 0;
    resp_t obs [64];
    int    pronto_cyc [64];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ifc.pronto && pronto_count < 64) begin
            obs[pronto_count]        <= {ifc.acertou_tiro, ifc.repetido, ifc.fim_jogo, ifc.vencedor};
            pronto_cyc[pronto_count] <= cyc;
            pronto_count             <= pronto_count + 1;
        end
    end

    resp_t sb [$];
    int    consumed = 0;
    vec_t  vecs [8];

    function automatic resp_t mk(input logic h, r, f, v);
        resp_t t;
        t = {h, r, f, v};
        return t;
    endfunction

    function automatic vec_t mkv(input logic [2:0] x, y, input logic j, input logic h, r);
        vec_t t;
        t.x = x;
        t.y = y;
        t.j = j;
        t.exp = mk(h, r, 1'b0, 1'b0);
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ifc.ocupado && n < 12);
        chk("idle_timeout", 32'(ifc.ocupado), 32'd0);
    endtask

    task automatic drain();
        resp_t e;
        #1;
        while (consumed < pronto_count) begin
            if (sb.size() == 0) begin
                chk("unexpected_pronto", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp", 32'(obs[consumed]), 32'(e));
            end
            consumed++;
        end
        chk("missing_resp", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic drive(input logic [2:0] x, y, input logic j);
        ifc.coord_x = x;
        ifc.coord_y = y;
        ifc.jogador = j;
        ifc.valida  = 1'b1;
    endtask

    task automatic shoot(input logic [2:0] x, y, input logic j, input resp_t e);
        @(negedge clk);
        drive(x, y, j);
        sb.push_back(e);
        @(posedge clk);
        #1 ifc.valida = 1'b0;
        wait_idle();
        drain();
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        ifc.clear = 1'b1;
        @(posedge clk);
        #1 ifc.clear = 1'b0;
    endtask

    initial begin
        int p0;
        logic seen;

        rst         = 1'b0;
        ifc.clear   = 1'b0;
        ifc.valida  = 1'b0;
        ifc.coord_x = '0;
        ifc.coord_y = '0;
        ifc.jogador = 1'b0;
        for (int p = 0; p < 2; p++)
            for (int c = 0; c < 64; c++) board[p][c] = 1'b0;

        repeat (2) @(negedge clk);
        chk("reset_outputs",
            32'({ifc.rd_en, ifc.rd_jogador, ifc.rd_addr, ifc.ocupado, ifc.pronto,
                 ifc.acertou_tiro, ifc.repetido, ifc.fim_jogo, ifc.vencedor}), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // miss on an empty board, with cycle-accurate read and response timing
        drive(3'd3, 3'd5, 1'b0);
        sb.push_back(mk(0, 0, 0, 0));
        @(posedge clk);
        #1 ifc.valida = 1'b0;
        chk("ler_rd_en", 32'(ifc.rd_en), 32'd1);
        chk("ler_rd_addr", 32'(ifc.rd_addr), 32'd43);
        chk("ler_rd_jogador", 32'(ifc.rd_jogador), 32'd1);
        chk("ler_ocupado", 32'(ifc.ocupado), 32'd1);
        @(posedge clk);
        #1 chk("aval_pronto", 32'(ifc.pronto), 32'd0);
        chk("aval_rd_en", 32'(ifc.rd_en), 32'd0);
        @(posedge clk);
        #1 chk("resp_pronto", 32'(ifc.pronto), 32'd1);
        wait_idle();
        drain();

        board[1][43] = 1'b1;
        for (int c = 8; c <= 18; c++) board[1][c] = 1'b1;
        board[0][5]  = 1'b1;
        board[0][63] = 1'b1;
        pulse_clear();

        vecs[0] = mkv(3'd3, 3'd5, 1'b0, 1, 0);
        vecs[1] = mkv(3'd3, 3'd5, 1'b0, 0, 1);
        vecs[2] = mkv(3'd0, 3'd0, 1'b0, 0, 0);
        vecs[3] = mkv(3'd0, 3'd0, 1'b0, 0, 1);
        vecs[4] = mkv(3'd5, 3'd0, 1'b1, 1, 0);
        vecs[5] = mkv(3'd0, 3'd0, 1'b1, 0, 0);
        vecs[6] = mkv(3'd7, 3'd7, 1'b1, 1, 0);
        vecs[7] = mkv(3'd7, 3'd7, 1'b1, 0, 1);
        for (int i = 0; i < 8; i++) shoot(vecs[i].x, vecs[i].y, vecs[i].j, vecs[i].exp);
        chk("hits_p1_after_table", 32'(dut.hits_p1), 32'd1);
        chk("hits_p2_after_table", 32'(dut.hits_p2), 32'd2);

        // P1 sinks the remaining 11 ship cells of P2; the last one wins
        for (int c = 8; c <= 18; c++)
            shoot(3'(c % 8), 3'(c / 8), 1'b0, mk(1, 0, (c == 18), 0));
        chk("win_fim", 32'(ifc.fim_jogo), 32'd1);
        chk("win_vencedor", 32'(ifc.vencedor), 32'd0);
        chk("win_hits", 32'(dut.hits_p1), 32'd12);

        @(negedge clk);
        drive(3'd4, 3'd4, 1'b1);
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            seen = seen | ifc.rd_en | ifc.pronto;
        end
        ifc.valida = 1'b0;
        chk("after_win_ignored", 32'(seen), 32'd0);
        drain();

        pulse_clear();
        chk("clear_fim", 32'(ifc.fim_jogo), 32'd0);
        chk("clear_hits_p1", 32'(dut.hits_p1), 32'd0);
        chk("clear_hits_p2", 32'(dut.hits_p2), 32'd0);

        // valida held for 6 edges: accepted at the 1st and 5th only
        p0 = pronto_count;
        @(negedge clk);
        drive(3'd1, 3'd1, 1'b0);
        sb.push_back(mk(1, 0, 0, 0));
        sb.push_back(mk(0, 1, 0, 0));
        repeat (6) @(posedge clk);
        #1 ifc.valida = 1'b0;
        wait_idle();
        drain();
        chk("busy_count", 32'(pronto_count - p0), 32'd2);
        chk("busy_spacing", 32'(pronto_cyc[p0 + 1] - pronto_cyc[p0]), 32'd4);

        // clear arriving in AVAL aborts the shot
        p0 = pronto_count;
        @(negedge clk);
        drive(3'd3, 3'd5, 1'b0);
        @(posedge clk);
        #1 ifc.valida = 1'b0;
        @(posedge clk);
        @(negedge clk);
        ifc.clear = 1'b1;
        @(posedge clk);
        #1 ifc.clear = 1'b0;
        repeat (4) @(negedge clk);
        drain();
        chk("clear_aval_no_pronto", 32'(pronto_count - p0), 32'd0);
        chk("clear_aval_hits", 32'(dut.hits_p1), 32'd0);
        chk("clear_aval_ocupado", 32'(ifc.ocupado), 32'd0);
        shoot(3'd3, 3'd5, 1'b0, mk(1, 0, 0, 0));
        shoot(3'd1, 3'd1, 1'b0, mk(1, 0, 0, 0));

        // asynchronous reset between edges while in LER
        p0 = pronto_count;
        @(negedge clk);
        drive(3'd3, 3'd5, 1'b0);
        @(posedge clk);
        #1 ifc.valida = 1'b0;
        #2 rst = 1'b0;
        #1 chk("async_reset_outputs",
               32'({ifc.rd_en, ifc.rd_jogador, ifc.rd_addr, ifc.ocupado, ifc.pronto,
                    ifc.acertou_tiro, ifc.repetido, ifc.fim_jogo, ifc.vencedor}), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        drain();
        chk("reset_no_pronto", 32'(pronto_count - p0), 32'd0);
        shoot(3'd3, 3'd5, 1'b0, mk(1, 0, 0, 0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
